l0_skew_buffer: RTL and testbench
=================================

L0_SKEW_BUFFER -- requirements
Module: l0_skew_buffer

Interface
REQ-001 SHALL have parameter row, default 8: number of array rows, one FIFO lane per row.
REQ-002 SHALL have parameter bw, default 4: activation bit-width per lane.
REQ-003 SHALL have parameter DEPTH, default 64: entries per lane, power of two, at least 2.
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset (low = reset).
REQ-006 SHALL have port wr  input  1: push one word from the xmem SRAM Q bus into all lanes.
REQ-007 SHALL have port in  input  row*bw: write word; lane i = in[bw*(i+1)-1 : bw*i].
REQ-008 SHALL have port rd  input  1: start a skewed pop wave; lane 0 pops immediately, lane i pops i cycles later.
REQ-009 SHALL have port out  output  row*bw: registered lane data to the PE array west inputs, same lane packing as in.
REQ-010 SHALL have port o_valid  output  row: bit i is high when out lane i holds data popped in the previous cycle.
REQ-011 SHALL have port o_full  output  1: high when any lane holds DEPTH entries.
REQ-012 SHALL have port o_ready  output  1: equal to NOT o_full.
REQ-013 SHALL have port o_empty  output  1: high when every lane holds 0 entries.

Function
REQ-014 SHALL implement each lane as a circular FIFO with log2(DEPTH)-bit read and write pointers and a (log2(DEPTH)+1)-bit occupancy count.
REQ-015 SHALL have pointers wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-016 SHALL have wr with o_full low write lane i of in at each lane's write pointer and advance that pointer in the same edge.
REQ-017 SHALL have wr with o_full high be ignored entirely: no lane written, no pointer moved.
REQ-018 SHALL keep a (row-1)-stage rd delay line: pop request for lane i at cycle t = rd sampled at cycle t-i; lane 0 uses rd directly.
REQ-019 SHALL have a lane pop request on a non-empty lane load out lane i from the read pointer, advance the pointer, and set o_valid[i] on the next cycle.
REQ-020 SHALL have a lane pop request on an empty lane be ignored: pointer unchanged, out lane i holds its last value, o_valid[i] low.
REQ-021 SHALL have o_valid[i] low in any cycle without a successful pop of lane i in the preceding edge, with out lane i holding its last value.
REQ-022 SHALL have a same-cycle push and pop on one lane both take effect, count unchanged; a pop on an empty lane does not return the word being pushed in that same edge.
REQ-023 SHALL have latency as follows: wr at edge n, rd at edge n+1 -> out lane 0 valid after edge n+1, lane i valid after edge n+1+i.
REQ-024 SHALL have o_full, o_ready and o_empty be combinational from the lane counts, reflecting state after the most recent edge.
REQ-025 SHALL allow lane counts to diverge during skewed reads; o_full and o_empty use the per-lane rule in REQ-011 and REQ-013.
REQ-026 SHALL allow back-to-back rd every cycle, streaming one diagonal wave per cycle with no bubbles while lanes are non-empty.

Reset
REQ-027 SHALL clear all pointers, counts, the rd delay line, out (to 0) and o_valid (to 0) immediately on reset low, independent of clk.
REQ-028 SHALL have reset asserted mid-stream discard all stored and in-flight pops; after reset rises o_empty=1, o_full=0, o_ready=1.
REQ-029 SHALL NOT require a reset value on the storage array; its contents are unobservable until written.

Verification
REQ-030 SHALL cover: reset low, then 3 wr of 0x76543210, 0x87654321, 0x98765432 and a single rd -> lane 0 out=0 valid on the first cycle, lane 7 out=7 on the eighth cycle, one valid bit per lane.
REQ-031 SHALL cover: 64 wr with rd low -> o_full=1 and o_ready=0 after the 64th edge; a 65th wr is dropped and a subsequent 64 rd return words 1..64 in order.
REQ-032 SHALL cover: 8 rd back-to-back after 8 wr -> o_valid walks a diagonal; at the 8th cycle all 8 bits are high, and lane 7 finishes 7 cycles after lane 0.
REQ-033 SHALL cover: rd with all lanes empty -> o_valid stays 0x00 and out is unchanged.
REQ-034 SHALL cover: wr and rd every cycle for 200 cycles with DEPTH=64 -> pointers wrap at least 3 times, data matches a reference queue, and o_full never asserts.
REQ-035 SHALL cover: reset pulsed low between edges mid-stream -> out=0 and o_valid=0 immediately, o_empty=1; no pops occur after release without new wr.

Source files
------------

// File: rtl/l0_skew_buffer.sv
// Per-row activation FIFOs feeding the PE array west edge. Reads ripple
// diagonally: lane i pops i cycles after lane 0 so data enters the array skewed.
module l0_skew_buffer #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [row*bw-1:0]   in,
  input  logic                rd,
  output logic [row*bw-1:0]   out,
  output logic [row-1:0]      o_valid,
  output logic                o_full,
  output logic                o_ready,
  output logic                o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [bw-1:0] mem [row][DEPTH];
  logic [AW-1:0] wptr [row];
  logic [AW-1:0] rptr [row];
  logic [AW:0]   cnt [row];
  logic [bw-1:0] out_q [row];
  logic [row-1:0] valid_q;
  logic [row-1:0] pop_req;
  logic [row-1:0] pop_ok;
  logic [row-1:0] lane_full;
  logic [row-1:0] lane_empty;
  logic [row-2:0] rd_pipe;
  logic           push;

  // Writes are all-or-nothing across lanes, gated by the global full flag.
  always_comb begin
    pop_req = {rd_pipe, rd};
    out     = '0;
    for (int i = 0; i < row; i++) begin
      lane_empty[i]       = (cnt[i] == '0);
      lane_full[i]        = (cnt[i] == FULL_CNT);
      pop_ok[i]           = pop_req[i] && !lane_empty[i];
      out[bw*i +: bw]     = out_q[i];
    end
    o_full  = |lane_full;
    o_ready = !o_full;
    o_empty = &lane_empty;
    push    = wr && !o_full;
  end

  assign o_valid = valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pipe <= '0;
      valid_q <= '0;
      for (int i = 0; i < row; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        cnt[i]   <= '0;
        out_q[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= rd;
      for (int i = 1; i < row - 1; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      valid_q <= pop_ok;
      for (int i = 0; i < row; i++) begin
        if (push) begin
          wptr[i] <= wptr[i] + PTR_ONE;
        end
        if (pop_ok[i]) begin
          rptr[i]  <= rptr[i] + PTR_ONE;
          out_q[i] <= mem[i][rptr[i]];
        end
        // A pop on an empty lane never sees the word pushed on the same edge.
        if (push && !pop_ok[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (!push && pop_ok[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < row; i++) begin
        mem[i][wptr[i]] <= in[bw*i +: bw];
      end
    end
  end

endmodule

// File: tb/tb_l0_skew_buffer.sv
// Bench for l0_skew_buffer: a directed vector table for the basic skewed read,
// then queue-model-checked sequences for fill, diagonal streaming, wrap and reset.
module tb_l0_skew_buffer;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [7:0]  valid;
  logic        full;
  logic        ready;
  logic        empty;

  int assertCount = 0;
  int failCount = 0;

  l0_skew_buffer #(.row(ROW), .bw(BW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (din),
    .rd      (rd),
    .out     (dout),
    .o_valid (valid),
    .o_full  (full),
    .o_ready (ready),
    .o_empty (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] expOut;
    logic [7:0]  expValid;
    logic        expFull;
    logic        expEmpty;
  } vec_t;

  vec_t vecs [12];

  // Reference model: one queue per lane plus the history of rd requests.
  logic [3:0] modelQ [ROW][$];
  logic [3:0] expOut [ROW];
  logic [7:0] expValid;
  logic [6:0] rdPast;
  logic       sawFull;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic modelFull();
    logic f = 1'b0;
    for (int i = 0; i < ROW; i++) if (modelQ[i].size() == DEPTH) f = 1'b1;
    return f;
  endfunction

  function automatic logic modelEmpty();
    logic e = 1'b1;
    for (int i = 0; i < ROW; i++) if (modelQ[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] packOut();
    logic [31:0] w = '0;
    for (int i = 0; i < ROW; i++) w[4*i +: 4] = expOut[i];
    return w;
  endfunction

  function automatic logic [31:0] laneWord(input int k);
    logic [31:0] w = '0;
    for (int i = 0; i < ROW; i++) w[4*i +: 4] = 4'(k + i);
    return w;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ROW; i++) begin
      modelQ[i].delete();
      expOut[i] = '0;
    end
    expValid = '0;
    rdPast   = '0;
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] d);
    logic [7:0] req;
    logic       pushOk;
    wr  = w;
    rd  = r;
    din = d;
    req    = {rdPast, r};
    pushOk = w && !modelFull();
    for (int i = 0; i < ROW; i++) begin
      expValid[i] = 1'b0;
      if (req[i] && modelQ[i].size() != 0) begin
        expOut[i]   = modelQ[i].pop_front();
        expValid[i] = 1'b1;
      end
    end
    if (pushOk) for (int i = 0; i < ROW; i++) modelQ[i].push_back(d[4*i +: 4]);
    rdPast = {rdPast[5:0], r};
    @(posedge clk);
    #1;
    checkOutput("model out", dout, packOut());
    checkOutput("model o_valid", 32'(valid), 32'(expValid));
    checkOutput("model o_full", 32'(full), 32'(modelFull()));
    checkOutput("model o_ready", 32'(ready), 32'(!modelFull()));
    checkOutput("model o_empty", 32'(empty), 32'(modelEmpty()));
  endtask

  task automatic pulseReset();
    wr    = 1'b0;
    rd    = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    modelReset();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h76543210, 32'h00000000, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h87654321, 32'h00000000, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h98765432, 32'h00000000, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0,        32'h00000000, 8'h01, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h00000010, 8'h02, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h00000210, 8'h04, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h00003210, 8'h08, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h00043210, 8'h10, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h00543210, 8'h20, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h06543210, 8'h40, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h76543210, 8'h80, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h76543210, 8'h00, 1'b0, 1'b0};
    modelReset();
    sawFull = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out", dout, 32'h0);
    checkOutput("reset o_valid", 32'(valid), 32'h0);
    checkOutput("reset o_empty", 32'(empty), 32'h1);
    checkOutput("reset o_full", 32'(full), 32'h0);
    checkOutput("reset o_ready", 32'(ready), 32'h1);
    #3;
    reset = 1'b1;

    // Three writes then a single rd: one valid bit walks lane 0 to lane 7.
    for (int k = 0; k < 12; k++) begin
      wr  = vecs[k].wr;
      rd  = vecs[k].rd;
      din = vecs[k].din;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d out", k), dout, vecs[k].expOut);
      checkOutput($sformatf("vec%0d o_valid", k), 32'(valid), 32'(vecs[k].expValid));
      checkOutput($sformatf("vec%0d o_full", k), 32'(full), 32'(vecs[k].expFull));
      checkOutput($sformatf("vec%0d o_empty", k), 32'(empty), 32'(vecs[k].expEmpty));
    end

    // Diagonal streaming: 8 writes then 8 back-to-back reads.
    pulseReset();
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 1'b0, laneWord(k));
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 1'b1, 32'h0);
      if (j == 7) checkOutput("diag all valid", 32'(valid), 32'hFF);
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (j == 0) checkOutput("diag lane0 done", 32'(valid), 32'hFE);
      if (j == 6) checkOutput("diag lane7 last", 32'(valid), 32'h80);
      if (j == 7) checkOutput("diag drained", 32'(valid), 32'h00);
    end

    // Fill to DEPTH, drop an extra write, then drain in order.
    pulseReset();
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1'b1, 1'b0, laneWord(k));
      if (k == DEPTH - 1) checkOutput("fill not full yet", 32'(full), 32'h0);
      if (k == DEPTH) begin
        checkOutput("fill o_full", 32'(full), 32'h1);
        checkOutput("fill o_ready", 32'(ready), 32'h0);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF);
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("drain last word", dout, 32'h76543210);
    checkOutput("drain o_empty", 32'(empty), 32'h1);

    // Reads with every lane empty pop nothing and hold out.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput("empty rd o_valid", 32'(valid), 32'h0);
    end
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("empty rd out held", dout, 32'h76543210);

    // Simultaneous wr and rd for 200 cycles wraps the pointers several times.
    pulseReset();
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'b1, 1'b1, $urandom());
      if (full) sawFull = 1'b1;
    end
    checkOutput("stream never full", 32'(sawFull), 32'h0);

    // Reset asserted between edges with pops in flight.
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset out", dout, 32'h0);
    checkOutput("async reset o_valid", 32'(valid), 32'h0);
    checkOutput("async reset o_empty", 32'(empty), 32'h1);
    checkOutput("async reset o_full", 32'(full), 32'h0);
    checkOutput("async reset o_ready", 32'(ready), 32'h1);
    wr = 1'b0;
    rd = 1'b0;
    #2;
    reset = 1'b1;
    modelReset();
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post reset no pops", 32'(valid), 32'h0);
    checkOutput("post reset o_empty", 32'(empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
